i2s_tx: RTL and testbench

I2S master transmitter: accepts stereo sample pairs over a valid/ready handshake and serialises them onto `sdo`. It generates `sclk` and `lrclk` from `clk` with a programmable divider. It sits at the DAC/codec output of the audio path and is the counterpart of `i2s_rx`. Its pins can be looped straight into `i2s_rx` (`sclk`→`sclk`, `lrclk`→`lrclk`, `sdo`→`sdi`), which recovers the same `ldata`/`rdata`.

---
 rtl/i2s_tx_if.sv | 12 +
 rtl/i2s_tx.sv | 126 ++++++++++++
 tb/tb_i2s_tx.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio producer (master) and i2s_tx (slave).
interface i2s_tx_if #(
  parameter int DW = 24
);
  logic [DW-1:0] ldata;
  logic [DW-1:0] rdata;
  logic          valid;
  logic          ready;

  modport master (output ldata, rdata, valid, input ready);
  modport slave  (input ldata, rdata, valid, output ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: divides clk into sclk/lrclk and shifts a one-deep
// buffered stereo pair out on sdo, MSB first with the standard one-bit delay.
module i2s_tx #(
  parameter int DW         = 24,
  parameter int FRAME_BITS = 32,
  parameter int SCLK_DIV   = 4
) (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave bus,
  output logic    sclk,
  output logic    lrclk,
  output logic    sdo,
  output logic    underflow
);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [BW-1:0] K_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] K_DATA   = BW'(DW);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_t;

  hold_state_t   hold_q, hold_d;
  logic [DW-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DW-1:0] act_l_q, act_l_d, act_r_q, act_r_d;
  logic [DW-1:0] sr_q, sr_d;
  logic [CW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          sclk_q, sclk_d, lrclk_q, lrclk_d, sdo_q, sdo_d, uf_q, uf_d;
  logic          wrap, fall, frame_start, accept;

  always_comb begin
    // NOTE: every variable gets its default first, so no path can infer a latch.
    hold_d   = hold_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    act_l_d  = act_l_q;
    act_r_d  = act_r_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    lrclk_d  = lrclk_q;
    sdo_d    = sdo_q;
    uf_d     = 1'b0;

    wrap        = (div_q == DIV_LAST);
    fall        = wrap && sclk_q;
    frame_start = fall && (bit_q == K_LAST) && lrclk_q;
    accept      = bus.valid && (hold_q == HOLD_EMPTY);

    div_d = wrap ? '0 : div_q + 1'b1;
    if (wrap) sclk_d = ~sclk_q;

    if (accept) begin
      hold_d   = HOLD_FULL;
      hold_l_d = bus.ldata;
      hold_r_d = bus.rdata;
    end

    if (fall) begin
      bit_d = (bit_q == K_LAST) ? '0 : bit_q + 1'b1;
      if (bit_q == K_LAST) lrclk_d = ~lrclk_q;

      // A same-cycle accept into an empty hold still underflows this frame.
      if (frame_start) begin
        if (hold_q == HOLD_FULL) begin
          act_l_d = hold_l_q;
          act_r_d = hold_r_q;
          hold_d  = HOLD_EMPTY;
        end else begin
          act_l_d = '0;
          act_r_d = '0;
          uf_d    = 1'b1;
        end
      end

      if (bit_d == '0) begin
        sdo_d = 1'b0;
        sr_d  = lrclk_d ? act_r_d : act_l_d;
      end else if (bit_d <= K_DATA) begin
        sdo_d = sr_q[DW-1];
        sr_d  = sr_q << 1;
      end else begin
        sdo_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q   <= HOLD_EMPTY;
      hold_l_q <= '0;
      hold_r_q <= '0;
      act_l_q  <= '0;
      act_r_q  <= '0;
      sr_q     <= '0;
      div_q    <= '0;
      bit_q    <= K_LAST;
      sclk_q   <= 1'b0;
      lrclk_q  <= 1'b1;
      sdo_q    <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      act_l_q  <= act_l_d;
      act_r_q  <= act_r_d;
      sr_q     <= sr_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      lrclk_q  <= lrclk_d;
      sdo_q    <= sdo_d;
      uf_q     <= uf_d;
    end
  end

  assign bus.ready = (hold_q == HOLD_EMPTY);
  assign sclk      = sclk_q;
  assign lrclk     = lrclk_q;
  assign sdo       = sdo_q;
  assign underflow = uf_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a behavioural I2S receiver decodes the pins
// into frames, compared against a frame schedule derived from accepted pairs.
module tb_i2s_tx;
  localparam int DW  = 24;
  localparam int FB  = 32;
  localparam int DIV = 4;
  localparam int FC  = 4 * DIV * FB;
  localparam int F0  = 2 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk, lrclk, sdo, underflow;

  i2s_tx_if #(.DW(DW)) bus ();

  i2s_tx #(.DW(DW), .FRAME_BITS(FB), .SCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sclk(sclk), .lrclk(lrclk), .sdo(sdo), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          uf;
    logic          ok;
  } frame_t;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;
  int uf_pulses = 0;
  int stray_uf  = 0;
  int pin_viol  = 0;
  frame_t        frames[$];
  int            acc_edge[$];
  logic [DW-1:0] acc_l[$];
  logic [DW-1:0] acc_r[$];

  // Receiver model: samples lrclk/sdo on sclk rising edges.
  initial begin : monitor
    logic p_sclk, p_lr, p_sdo, s_lr, active, fuf, cur_uf, fok;
    int sb;
    logic [DW-1:0] wl, wr;
    p_sclk = 1'b0; p_lr = 1'b1; p_sdo = 1'b0; s_lr = 1'b1;
    active = 1'b0; fuf = 1'b0; cur_uf = 1'b0; fok = 1'b1; sb = 0; wl = '0; wr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        p_sclk = 1'b0; p_lr = 1'b1; p_sdo = 1'b0; s_lr = 1'b1; active = 1'b0; sb = 0;
      end else begin
        if (sdo !== p_sdo && !(p_sclk && !sclk)) pin_viol++;
        if (lrclk !== p_lr && !(p_sclk && !sclk)) pin_viol++;
        if (underflow === 1'b1) begin
          uf_pulses++;
          if (!(p_lr && !lrclk)) stray_uf++;
        end
        if (p_lr && !lrclk) fuf = underflow;
        if (sclk && !p_sclk) begin
          if (lrclk !== s_lr) begin
            sb = 0;
            s_lr = lrclk;
            if (!lrclk) begin
              active = 1'b1; wl = '0; wr = '0; fok = 1'b1; cur_uf = fuf;
            end
          end else begin
            sb++;
          end
          if (active) begin
            if (sb >= 1 && sb <= DW) begin
              if (lrclk) wr = {wr[DW-2:0], sdo};
              else       wl = {wl[DW-2:0], sdo};
            end else if (sdo !== 1'b0) begin
              fok = 1'b0;
            end
            if (lrclk && sb == FB - 1) begin
              frames.push_back({wl, wr, cur_uf, fok});
              active = 1'b0;
            end
          end
        end
        p_sclk = sclk; p_lr = lrclk; p_sdo = sdo;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame k starts at edge F0+k*FC and plays the oldest unplayed pair accepted strictly before it.
  function automatic frame_t model_frame(input int k);
    frame_t m;
    int idx = 0;
    m = '0;
    for (int f = 0; f <= k; f++) begin
      m.l = '0; m.r = '0; m.uf = 1'b1; m.ok = 1'b1;
      if (idx < acc_edge.size() && acc_edge[idx] < F0 + f * FC) begin
        m.l = acc_l[idx]; m.r = acc_r[idx]; m.uf = 1'b0;
        idx++;
      end
    end
    return m;
  endfunction

  task automatic step();
    if (bus.valid && bus.ready && !rst) begin
      acc_edge.push_back(e + 1);
      acc_l.push_back(bus.ldata);
      acc_r.push_back(bus.rdata);
    end
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] l, input logic [DW-1:0] r);
    bus.valid = v;
    bus.ldata = l;
    bus.rdata = r;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frames.delete(); acc_edge.delete(); acc_l.delete(); acc_r.delete();
    uf_pulses = 0;
    e = 0;
    rst = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string name);
    int budget;
    budget = (n + 2) * FC;
    while (frames.size() < n && budget > 0) begin
      step();
      budget--;
    end
    n_checks++;
    if (frames.size() < n) begin
      $display("FAIL %s timeout: got %0d frames, expected %0d", name, frames.size(), n);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({sclk, lrclk, sdo, bus.ready, underflow} !== 5'b01010) begin
      $display("FAIL reset_values: got sclk/lrclk/sdo/ready/uf=%b, expected 01010",
               {sclk, lrclk, sdo, bus.ready, underflow});
      n_fail++;
    end
  endtask

  task automatic test_basic();
    frame_t got;
    reset_dut();
    drive(1'b1, 24'hA5F00F, 24'h123456);
    step();
    drive(1'b0, DW'($urandom()), DW'($urandom()));
    n_checks++;
    if (bus.ready !== 1'b0) begin $display("FAIL basic_ready_drop: got %b expected 0", bus.ready); n_fail++; end
    while (e < F0) begin
      step();
      if (e == DIV - 1) begin
        n_checks++;
        if (sclk !== 1'b0) begin $display("FAIL basic_sclk_pre_rise: got %b expected 0", sclk); n_fail++; end
      end
      if (e == DIV) begin
        n_checks++;
        if (sclk !== 1'b1) begin $display("FAIL basic_sclk_rise: got %b expected 1", sclk); n_fail++; end
      end
      if (e == F0 - 1) begin
        n_checks++;
        if (lrclk !== 1'b1) begin $display("FAIL basic_lrclk_pre: got %b expected 1", lrclk); n_fail++; end
      end
    end
    n_checks++;
    if ({sclk, lrclk, underflow, bus.ready} !== 4'b0001) begin
      $display("FAIL basic_frame_start: got sclk/lrclk/uf/ready=%b expected 0001",
               {sclk, lrclk, underflow, bus.ready});
      n_fail++;
    end
    wait_frames(1, "basic");
    got = (frames.size() > 0) ? frames[0] : '0;
    n_checks++;
    if (got.l !== 24'hA5F00F || got.r !== 24'h123456 || got.uf !== 1'b0 || got.ok !== 1'b1) begin
      $display("FAIL basic_frame: got l=%h r=%h uf=%b ok=%b, expected l=a5f00f r=123456 uf=0 ok=1",
               got.l, got.r, got.uf, got.ok);
      n_fail++;
    end
  endtask

  task automatic test_underflow();
    frame_t got, exp;
    reset_dut();
    drive(1'b1, DW'($urandom()), DW'($urandom()));
    step();
    drive(1'b0, DW'($urandom()), DW'($urandom()));
    wait_frames(2, "underflow");
    for (int k = 0; k < 2; k++) begin
      exp = model_frame(k);
      got = (k < frames.size()) ? frames[k] : '0;
      n_checks++;
      if (k >= frames.size() || got !== exp) begin
        $display("FAIL underflow_frame%0d: got l=%h r=%h uf=%b ok=%b, expected l=%h r=%h uf=%b ok=%b",
                 k, got.l, got.r, got.uf, got.ok, exp.l, exp.r, exp.uf, exp.ok);
        n_fail++;
      end
    end
    n_checks++;
    if (uf_pulses !== 1) begin $display("FAIL underflow_pulses: got %0d expected 1", uf_pulses); n_fail++; end
  endtask

  task automatic test_coincident();
    frame_t got, exp;
    reset_dut();
    while (e < F0 - 1) step();
    drive(1'b1, DW'($urandom()), DW'($urandom()));
    step();
    drive(1'b0, DW'($urandom()), DW'($urandom()));
    n_checks++;
    if ({underflow, bus.ready} !== 2'b10) begin
      $display("FAIL coincident_start: got uf/ready=%b expected 10", {underflow, bus.ready});
      n_fail++;
    end
    wait_frames(2, "coincident");
    for (int k = 0; k < 2; k++) begin
      exp = model_frame(k);
      got = (k < frames.size()) ? frames[k] : '0;
      n_checks++;
      if (k >= frames.size() || got !== exp) begin
        $display("FAIL coincident_frame%0d: got l=%h r=%h uf=%b ok=%b, expected l=%h r=%h uf=%b ok=%b",
                 k, got.l, got.r, got.uf, got.ok, exp.l, exp.r, exp.uf, exp.ok);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    frame_t got, exp;
    logic prev_rdy;
    int viol;
    reset_dut();
    drive(1'b1, DW'($urandom()), DW'($urandom()));
    prev_rdy = 1'b0;
    viol = 0;
    while (e < F0 + 8 * FC + FC / 2) begin
      if (bus.ready && prev_rdy) viol++;
      prev_rdy = bus.ready;
      step();
      drive(1'b1, DW'($urandom()), DW'($urandom()));
    end
    bus.valid = 1'b0;
    n_checks++;
    if (acc_edge.size() !== 10) begin $display("FAIL b2b_accepts: got %0d expected 10", acc_edge.size()); n_fail++; end
    n_checks++;
    if (viol !== 0) begin $display("FAIL b2b_ready_pulse: got %0d double-ready cycles expected 0", viol); n_fail++; end
    wait_frames(9, "b2b");
    for (int k = 0; k < 9; k++) begin
      exp = model_frame(k);
      got = (k < frames.size()) ? frames[k] : '0;
      n_checks++;
      if (k >= frames.size() || got !== exp) begin
        $display("FAIL b2b_frame%0d: got l=%h r=%h uf=%b ok=%b, expected l=%h r=%h uf=%b ok=%b",
                 k, got.l, got.r, got.uf, got.ok, exp.l, exp.r, exp.uf, exp.ok);
        n_fail++;
      end
    end
    n_checks++;
    if (uf_pulses !== 0) begin $display("FAIL b2b_underflow: got %0d pulses expected 0", uf_pulses); n_fail++; end
  endtask

  task automatic test_reset_mid();
    frame_t got, exp;
    reset_dut();
    drive(1'b1, DW'($urandom()), DW'($urandom()));
    step();
    drive(1'b0, DW'($urandom()), DW'($urandom()));
    // Left slot bit k=10 starts at edge F0 + 10*2*DIV.
    while (e < F0 + 20 * DIV + 1) step();
    n_checks++;
    if (lrclk !== 1'b0) begin $display("FAIL midrst_in_left: got lrclk=%b expected 0", lrclk); n_fail++; end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sclk, lrclk, sdo, bus.ready, underflow} !== 5'b01010) begin
      $display("FAIL midrst_values: got sclk/lrclk/sdo/ready/uf=%b expected 01010",
               {sclk, lrclk, sdo, bus.ready, underflow});
      n_fail++;
    end
    reset_dut();
    while (e < F0) begin
      step();
      if (e == F0 - 1) begin
        n_checks++;
        if (lrclk !== 1'b1) begin $display("FAIL midrst_lrclk_pre: got %b expected 1", lrclk); n_fail++; end
      end
    end
    n_checks++;
    if ({lrclk, underflow} !== 2'b01) begin
      $display("FAIL midrst_first_frame: got lrclk/uf=%b expected 01", {lrclk, underflow});
      n_fail++;
    end
    wait_frames(1, "midrst");
    exp = model_frame(0);
    got = (frames.size() > 0) ? frames[0] : '0;
    n_checks++;
    if (frames.size() == 0 || got !== exp) begin
      $display("FAIL midrst_frame: got l=%h r=%h uf=%b ok=%b, expected l=%h r=%h uf=%b ok=%b",
               got.l, got.r, got.uf, got.ok, exp.l, exp.r, exp.uf, exp.ok);
      n_fail++;
    end
  endtask

  task automatic test_pin_timing();
    n_checks++;
    if (pin_viol !== 0) begin $display("FAIL pin_timing: got %0d off-edge changes expected 0", pin_viol); n_fail++; end
    n_checks++;
    if (stray_uf !== 0) begin $display("FAIL stray_underflow: got %0d expected 0", stray_uf); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    test_pin_timing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
